// File: rtl/fb_scan_reader_pkg.sv
// Shared types and constants for the frame-buffer scan reader.
package fb_scan_reader_pkg;

    localparam int PIX_W  = 24;
    localparam int LANE_R = 0;
    localparam int LANE_G = 8;
    localparam int LANE_B = 16;

    // Scan FSM encoding. DRAIN waits for the output FIFO to empty after a one-shot frame.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    // Output FIFO entry: pixel plus start-of-frame and end-of-line markers.
    typedef struct packed {
        logic [PIX_W-1:0] rgb;
        logic             sof;
        logic             eol;
    } pix_entry_t;

    localparam int ENT_W = $bits(pix_entry_t);

endpackage

// File: rtl/fb_pix_fifo.sv
// Two-entry output FIFO for the scan reader; head entry is held stable until popped.
module fb_pix_fifo
    import fb_scan_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  pix_entry_t din,
    output pix_entry_t dout,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    pix_entry_t slot0;
    pix_entry_t slot1;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = rd_ptr ? slot1 : slot0;

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) slot1 <= din;
                else        slot0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer read master: walks the frame in raster order and streams pixels out.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// SETUP   | mem_addr/mem_rd driven, waiting for a free FIFO slot
// STROBE  | mem_en high for one cycle, RAM captures the read
// CAPTURE | push read data into the FIFO (or discard on abort), advance
// DRAIN   | one-shot frame fully read, waiting for the FIFO to empty
module fb_scan_reader
    import fb_scan_reader_pkg::*;
#(
    parameter int H_RES     = 100,
    parameter int V_RES     = 100,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_en,
    input  logic [PIX_W-1:0] mem_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_rgb,
    output logic             pix_sof,
    output logic             pix_eol
);

    localparam int             XW     = $clog2(H_RES + 1);
    localparam int             YW     = $clog2(V_RES + 1);
    localparam logic [XW-1:0]  X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(V_RES - 1);
    localparam logic [15:0]    BASE   = 16'(BASE_ADDR);

    state_t        state, state_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [15:0]   addr, addr_nxt;
    logic          abort_pend, abort_pend_nxt;
    logic [YW-1:0] out_y;
    logic          mem_en_q;
    logic          mem_rd_q;
    logic          frame_done_q;

    logic          push;
    logic          pop;
    logic          flush;
    pix_entry_t    push_ent;
    pix_entry_t    head;
    logic          full;
    logic          empty;
    logic [1:0]    count;
    logic          slot_free;
    logic          last_px;

    fb_pix_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_ent),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign pop       = ~empty & pix_ready;
    // A slot freed by this cycle's pop already counts as free.
    assign slot_free = ~full | pop;
    assign last_px   = (x == X_LAST) && (y == Y_LAST);

    // Next-state, scan position and FIFO control.
    always_comb begin
        state_nxt      = state;
        x_nxt          = x;
        y_nxt          = y;
        addr_nxt       = addr;
        abort_pend_nxt = abort_pend;
        push           = 1'b0;
        flush          = 1'b0;
        push_ent.rgb   = mem_data;
        push_ent.sof   = (x == '0) && (y == '0);
        push_ent.eol   = (x == X_LAST);

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    addr_nxt  = BASE;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (slot_free) begin
                    state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                // The strobe already issued completes; its data is dropped in CAPTURE.
                state_nxt = S_CAPTURE;
                if (abort) begin
                    flush          = 1'b1;
                    abort_pend_nxt = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (abort || abort_pend) begin
                    flush          = 1'b1;
                    abort_pend_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else begin
                    push      = 1'b1;
                    addr_nxt  = addr + 16'd1;
                    x_nxt     = x + 1'b1;
                    state_nxt = S_SETUP;
                    if (x == X_LAST) begin
                        x_nxt = '0;
                        y_nxt = y + 1'b1;
                    end
                    if (last_px) begin
                        x_nxt = '0;
                        y_nxt = '0;
                        if (continuous) begin
                            addr_nxt = BASE;
                        end else begin
                            // Hold the last address so addr stays inside the frame.
                            addr_nxt  = addr;
                            state_nxt = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (count == 2'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM, scan position and registered RAM strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            addr       <= BASE;
            abort_pend <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            addr       <= addr_nxt;
            abort_pend <= abort_pend_nxt;
            mem_en_q   <= (state_nxt == S_STROBE);
            mem_rd_q   <= (state_nxt inside {S_SETUP, S_STROBE, S_CAPTURE});
        end
    end

    // Output-side line counter; frame_done fires when the last line's eol pixel leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_y        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= pop & head.eol & (out_y == Y_LAST) & ~flush;
            if (flush) begin
                out_y <= '0;
            end else if (pop && head.eol) begin
                out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign frame_done = frame_done_q;
    assign mem_addr   = addr;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = 1'b0;
    assign mem_en     = mem_en_q;
    assign pix_valid  = ~empty;
    assign pix_rgb    = head.rgb;
    assign pix_sof    = head.sof;
    assign pix_eol    = head.eol;

endmodule
